// File: rtl/c_state_update.sv
// LSTM cell-state update: Ct = f*Ct-1 + i*g in the quantized state domain.
// One shared signed multiplier is stepped by a small FSM; Sys_Ct feeds TMQ.
module c_state_update #(
    parameter logic [9:0] SCALE_STATE       = 10'd128,
    parameter logic [7:0] ZERO_STATE        = 8'd128,
    parameter logic [9:0] OUT_SCALE_SIGMOID = 10'd256,
    parameter logic [7:0] OUT_ZERO_SIGMOID  = 8'd0,
    parameter logic [9:0] OUT_SCALE_TANH    = 10'd128,
    parameter logic [7:0] OUT_ZERO_TANH     = 8'd128
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] f_q,
    input  logic [7:0] i_q,
    input  logic [7:0] g_q,
    input  logic       seq_first,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Sys_Ct
);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, FIN, DONE} state_t;

    localparam logic signed [31:0] ZS     = 32'(ZERO_STATE);
    localparam logic signed [31:0] ZSIG   = 32'(OUT_ZERO_SIGMOID);
    localparam logic signed [31:0] ZTANH  = 32'(OUT_ZERO_TANH);
    localparam logic signed [31:0] SC_ST  = 32'(SCALE_STATE);
    localparam logic signed [31:0] SC_SIG = 32'(OUT_SCALE_SIGMOID);
    localparam logic signed [31:0] SC_TNH = 32'(OUT_SCALE_TANH);
    localparam logic signed [31:0] DIV2   = SC_SIG * SC_TNH;

    state_t state, state_nxt;

    logic [7:0]        f_r, i_r, g_r, c_prev;
    logic signed [31:0] p1, p2;
    logic signed [31:0] mul_a, mul_b, mul_y;
    logic signed [31:0] t1, t2, s;
    logic [7:0]        ct_sat;

    function automatic logic signed [31:0] zx(input logic [7:0] v);
        return $signed({24'd0, v});
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = FIN;
            FIN:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // MUL1 forms f*(Ct-1), every other state presents the i*g operands
    always_comb begin
        mul_a = zx(i_r) - ZSIG;
        mul_b = zx(g_r) - ZTANH;
        if (state == MUL1) begin
            mul_a = zx(f_r) - ZSIG;
            mul_b = zx(c_prev) - ZS;
        end
    end

    assign mul_y = mul_a * mul_b;
    assign t1    = p1 / SC_SIG;
    assign t2    = (p2 * SC_ST) / DIV2;
    assign s     = t1 + t2 + ZS;

    always_comb begin
        ct_sat = s[7:0];
        unique case (1'b1)
            s[31]:          ct_sat = 8'd0;
            (s > 32'sd255): ct_sat = 8'd255;
            default:        ct_sat = s[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_r    <= '0;
            i_r    <= '0;
            g_r    <= '0;
            c_prev <= '0;
            p1     <= '0;
            p2     <= '0;
            Sys_Ct <= ZERO_STATE;
        end else begin
            if (state == IDLE && in_valid) begin
                f_r    <= f_q;
                i_r    <= i_q;
                g_r    <= g_q;
                c_prev <= seq_first ? ZERO_STATE : Sys_Ct;
            end
            if (state == MUL1) p1 <= mul_y;
            if (state == MUL2) p2 <= mul_y;
            if (state == FIN)  Sys_Ct <= ct_sat;
        end
    end

endmodule

// File: tb/tb_c_state_update.sv
// Randomized bench for c_state_update against an arithmetic model of
// the cell-state update rule, plus directed boundary sequences.
module tb_c_state_update;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] f_q = '0;
    logic [7:0] i_q = '0;
    logic [7:0] g_q = '0;
    logic       seq_first = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] Sys_Ct;

    int n_vec = 0;
    int n_bad = 0;
    int ct_model = 128;

    c_state_update dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_q       (f_q),
        .i_q       (i_q),
        .g_q       (g_q),
        .seq_first (seq_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sys_Ct    (Sys_Ct)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ct = f*Ct-1 + i*g with the default scales/zero points, int division
    function automatic int model(int f, int i, int g, int cp);
        int t1, t2, s;
        t1 = (f * (cp - 128)) / 256;
        t2 = (i * (g - 128) * 128) / (256 * 128);
        s  = t1 + t2 + 128;
        if (s < 0)   return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic xact(input int f, input int i, input int g,
                        input bit sf, input int hold, input bit poke);
        int exp, lat, held;
        exp = model(f, i, g, sf ? 128 : ct_model);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        f_q = 8'(f); i_q = 8'(i); g_q = 8'(g);
        seq_first = sf;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seq_first = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        check("ct", Sys_Ct, exp);
        held = Sys_Ct;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (poke) begin
                in_valid = 1'b1;
                seq_first = 1'b1;
                f_q = 8'($urandom); i_q = 8'($urandom); g_q = 8'($urandom);
            end
            check("hold_valid", out_valid, 1);
            check("hold_ct", Sys_Ct, held);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        seq_first = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_idle", in_ready, 1);
        check("release_valid", out_valid, 0);
        check("release_ct", Sys_Ct, exp);
        out_ready = 1'b0;
        ct_model = exp;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ct", Sys_Ct, 128);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ct", Sys_Ct, 128);
        check("idle_out_valid", out_valid, 0);

        xact(128, 0, 0, 1, 0, 0);
        check("dir_zero", ct_model, 128);
        xact(0, 255, 193, 1, 0, 0);
        check("dir_192", ct_model, 192);
        xact(128, 0, 77, 0, 0, 0);
        check("dir_feedback", ct_model, 160);
        xact(0, 255, 255, 1, 0, 0);
        check("dir_trunc", ct_model, 254);
        xact(255, 255, 255, 0, 0, 0);
        check("dir_sat_hi", ct_model, 255);
        xact(255, 255, 0, 0, 10, 1);
        check("dir_neg_t2", ct_model, 127);
        xact(0, 255, 0, 1, 0, 0);
        xact(255, 255, 0, 0, 0, 0);
        check("dir_to_zero", ct_model, 0);
        xact(255, 255, 0, 0, 0, 0);
        check("dir_sat_lo", ct_model, 0);

        // abort while in MUL2
        @(negedge clk);
        f_q = 8'd200; i_q = 8'd200; g_q = 8'd200;
        seq_first = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_ct", Sys_Ct, 128);
        @(negedge clk);
        rstn = 1'b1;
        ct_model = 128;
        xact(100, 50, 220, 0, 1, 0);

        for (int n = 0; n < 200; n++) begin
            xact($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
